// File: rtl/instr_encoder.sv
// Instruction encoder: packs MIPS instruction fields into 32-bit words and
// streams them into instruction memory at sequential word addresses.
// Input side uses a valid/ready handshake, output side a write/ack handshake.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter int          DEPTH     = 1024,
    parameter int          CW        = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    fmt,
    input  logic [5:0]    op,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    input  logic [4:0]    rd,
    input  logic [4:0]    shamt,
    input  logic [5:0]    funct,
    input  logic [15:0]   imm16,
    input  logic [25:0]   imm26,
    input  logic [31:0]   raw,
    input  logic          last,
    output logic          im_we,
    output logic [31:0]   im_addr,
    output logic [31:0]   im_wdata,
    input  logic          im_ack,
    output logic [CW-1:0] count,
    output logic          busy,
    output logic          done,
    output logic          overflow
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};

    // Assemble the instruction word for the selected format; unused fields drop out.
    function automatic logic [31:0] pack_word(
        input logic [1:0]  f,
        input logic [5:0]  f_op,
        input logic [4:0]  f_rs,
        input logic [4:0]  f_rt,
        input logic [4:0]  f_rd,
        input logic [4:0]  f_shamt,
        input logic [5:0]  f_funct,
        input logic [15:0] f_imm16,
        input logic [25:0] f_imm26,
        input logic [31:0] f_raw
    );
        logic [31:0] w;
        case (f)
            2'b00:   w = {f_op, f_rs, f_rt, f_rd, f_shamt, f_funct};
            2'b01:   w = {f_op, f_rs, f_rt, f_imm16};
            2'b10:   w = {f_op, f_imm26};
            2'b11:   w = f_raw;
            default: w = f_raw;
        endcase
        return w;
    endfunction

    state_t        state_r;
    state_t        state_next_s;
    logic          last_r;
    logic [CW-1:0] count_inc_s;
    logic          depth_hit_s;
    logic          in_ready_s;
    logic          im_we_s;
    logic          busy_s;
    logic          done_s;
    logic [31:0]   packed_s;

    assign count_inc_s = count + ONE_C;
    assign depth_hit_s = (count_inc_s == DEPTH_C);
    assign packed_s    = pack_word(fmt, op, rs, rt, rd, shamt, funct, imm16, imm26, raw);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: start arms from IDLE/DONE, ack retires a write.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_ARMED;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (in_valid) begin
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = ST_ARMED;
                end
            end
            ST_WRITE: begin
                if (!im_ack) begin
                    state_next_s = ST_WRITE;
                end else if (last_r || depth_hit_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_ARMED;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_next_s = ST_ARMED;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the status outputs leave a flop.
    always_comb begin
        in_ready_s = 1'b0;
        im_we_s    = 1'b0;
        busy_s     = 1'b0;
        done_s     = 1'b0;
        case (state_next_s)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_ARMED: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b1;
            end
            ST_WRITE: begin
                im_we_s = 1'b1;
                busy_s  = 1'b1;
            end
            ST_DONE: begin
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Datapath and status registers: address/count/data capture per state.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready <= 1'b0;
            im_we    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            im_addr  <= BASE_ADDR;
            im_wdata <= 32'h0000_0000;
            count    <= '0;
            overflow <= 1'b0;
            last_r   <= 1'b0;
        end else begin
            in_ready <= in_ready_s;
            im_we    <= im_we_s;
            busy     <= busy_s;
            done     <= done_s;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        im_addr  <= BASE_ADDR;
                        count    <= '0;
                        overflow <= 1'b0;
                    end else begin
                        overflow <= overflow;
                    end
                end
                ST_ARMED: begin
                    if (in_valid) begin
                        im_wdata <= packed_s;
                        last_r   <= last;
                    end else begin
                        last_r <= last_r;
                    end
                end
                ST_WRITE: begin
                    if (im_ack) begin
                        count   <= count_inc_s;
                        im_addr <= im_addr + 32'd4;
                        if (!last_r && depth_hit_s) begin
                            overflow <= 1'b1;
                        end else begin
                            overflow <= overflow;
                        end
                    end else begin
                        count <= count;
                    end
                end
                default: begin
                    count <= count;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a full-depth instance and a 4-deep
// instance share stimulus; a negedge scoreboard checks every acked write.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  fmt = 2'b00;
    logic [5:0]  op = 6'd0;
    logic [4:0]  rs = 5'd0, rt = 5'd0, rd = 5'd0, shamt = 5'd0;
    logic [5:0]  funct = 6'd0;
    logic [15:0] imm16 = 16'd0;
    logic [25:0] imm26 = 26'd0;
    logic [31:0] raw = 32'd0;
    logic        last = 1'b0;
    logic        im_ack = 1'b0;

    logic        in_ready, im_we, busy, done, overflow;
    logic [31:0] im_addr, im_wdata;
    logic [10:0] count;

    logic        s_in_ready, s_im_we, s_busy, s_done, s_overflow;
    logic [31:0] s_im_addr, s_im_wdata;
    logic [2:0]  s_count;

    logic        sel_small = 1'b0;
    logic [63:0] exp_q[$];
    logic [31:0] next_addr = 32'h0000_3000;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;

    instr_encoder u_dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm16(imm16), .imm26(imm26), .raw(raw), .last(last),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .im_ack(im_ack),
        .count(count), .busy(busy), .done(done), .overflow(overflow)
    );

    instr_encoder #(.DEPTH(4), .CW(3)) u_small (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
        .fmt(fmt), .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm16(imm16), .imm26(imm26), .raw(raw), .last(last),
        .im_we(s_im_we), .im_addr(s_im_addr), .im_wdata(s_im_wdata), .im_ack(im_ack),
        .count(s_count), .busy(s_busy), .done(s_done), .overflow(s_overflow)
    );

    wire        mon_we    = sel_small ? s_im_we    : im_we;
    wire [31:0] mon_addr  = sel_small ? s_im_addr  : im_addr;
    wire [31:0] mon_wdata = sel_small ? s_im_wdata : im_wdata;
    wire        mon_ready = sel_small ? s_in_ready : in_ready;
    wire        mon_done  = sel_small ? s_done     : done;

    // Clock generation.
    always #5 clk = ~clk;

    // Cycle counter for throughput checks.
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every acked write must match the oldest expected word.
    always @(negedge clk) begin
        if (mon_we && im_ack) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL write_unexpected: got addr=%h data=%h, expected no write", mon_addr, mon_wdata);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({mon_addr, mon_wdata} !== e)
                    begin
                        n_err++;
                        $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                                 mon_addr, mon_wdata, e[63:32], e[31:0]);
                    end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        next_addr = 32'h0000_3000;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!mon_ready && k < 50) begin
            tick();
            k++;
        end
        if (k >= 50) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout: in_ready=0 after %0d cycles, expected 1", k);
        end
    endtask

    task automatic wait_done();
        int k = 0;
        while (!mon_done && k < 50) begin
            tick();
            k++;
        end
        if (k >= 50) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: done=0 after %0d cycles, expected 1", k);
        end
    endtask

    // Present the currently driven tuple and record the word it must produce.
    task automatic send(input logic l, input logic [31:0] exp_word);
        wait_ready();
        last = l;
        in_valid = 1'b1;
        exp_q.push_back({next_addr, exp_word});
        next_addr = next_addr + 32'd4;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic set_fields(input logic [1:0] f, input logic [5:0] o, input logic [4:0] s,
                              input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                              input logic [5:0] fu, input logic [15:0] i16,
                              input logic [25:0] i26, input logic [31:0] rw);
        fmt = f; op = o; rs = s; rt = t; rd = d; shamt = sh; funct = fu;
        imm16 = i16; imm26 = i26; raw = rw;
    endtask

    task automatic check_q_empty(input string name);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_pending: got %0d unwritten words, expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_cmp++;
        if ({in_ready, im_we, busy, done, overflow} !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_flags: got %b, expected 00000", {in_ready, im_we, busy, done, overflow});
        end
        n_cmp++;
        if (im_addr !== 32'h0000_3000 || im_wdata !== 32'h0 || count !== 11'd0) begin
            n_err++;
            $display("FAIL reset_regs: got addr=%h data=%h count=%0d, expected 3000/0/0", im_addr, im_wdata, count);
        end
    endtask

    task automatic test_rtype();
        im_ack = 1'b1;
        do_start();
        n_cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL rtype_armed: got in_ready=%b busy=%b, expected 1 1", in_ready, busy);
        end
        // unused imm fields carry garbage that must not leak into the word
        set_fields(2'b00, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'hBEEF, 26'h3FF_FFFF, 32'hDEAD_BEEF);
        send(1'b1, 32'h0022_1821);
        wait_done();
        n_cmp++;
        if (done !== 1'b1 || count !== 11'd1 || overflow !== 1'b0 || busy !== 1'b0 || im_we !== 1'b0) begin
            n_err++;
            $display("FAIL rtype_done: got done=%b count=%0d ovf=%b busy=%b we=%b, expected 1 1 0 0 0",
                     done, count, overflow, busy, im_we);
        end
        check_q_empty("rtype");
    endtask

    task automatic test_back_to_back();
        int c0;
        im_ack = 1'b1;
        do_start();
        c0 = cyc;
        set_fields(2'b01, 6'h0D, 5'd0, 5'd1, 5'd31, 5'd31, 6'h3F, 16'h1234, 26'h155_5555, 32'h0);
        send(1'b0, 32'h3401_1234);
        set_fields(2'b10, 6'd2, 5'd7, 5'd7, 5'd7, 5'd7, 6'h3F, 16'hFFFF, 26'h000_0C00, 32'h0);
        send(1'b0, 32'h0800_0C00);
        set_fields(2'b11, 6'h3F, 5'd9, 5'd9, 5'd9, 5'd9, 6'h3F, 16'h0, 26'h0, 32'hFFFF_FFFF);
        send(1'b1, 32'hFFFF_FFFF);
        wait_done();
        n_cmp++;
        if (count !== 11'd3 || done !== 1'b1) begin
            n_err++;
            $display("FAIL ijr_count: got count=%0d done=%b, expected 3 1", count, done);
        end
        n_cmp++;
        if (cyc - c0 !== 6) begin
            n_err++;
            $display("FAIL ijr_throughput: got %0d cycles for 3 words, expected 6", cyc - c0);
        end
        check_q_empty("ijr");
    endtask

    task automatic test_ack_stall();
        im_ack = 1'b0;
        do_start();
        set_fields(2'b00, 6'd0, 5'd4, 5'd5, 5'd6, 5'd2, 6'h20, 16'h0, 26'h0, 32'h0);
        send(1'b1, 32'h0085_30A0);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (im_we !== 1'b1 || im_addr !== 32'h0000_3000 || im_wdata !== 32'h0085_30A0 ||
                in_ready !== 1'b0 || count !== 11'd0) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got we=%b addr=%h data=%h rdy=%b count=%0d, expected 1 3000 008530a0 0 0",
                         i, im_we, im_addr, im_wdata, in_ready, count);
            end
            tick();
        end
        im_ack = 1'b1;
        tick();
        im_ack = 1'b0;
        n_cmp++;
        if (count !== 11'd1 || done !== 1'b1 || im_we !== 1'b0) begin
            n_err++;
            $display("FAIL stall_ack: got count=%0d done=%b we=%b, expected 1 1 0", count, done, im_we);
        end
        check_q_empty("stall");
    endtask

    task automatic test_overflow();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        sel_small = 1'b1;
        im_ack = 1'b1;
        do_start();
        for (int i = 0; i < 4; i++) begin
            set_fields(2'b11, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 32'hA5A5_0000 + i);
            send(1'b0, 32'hA5A5_0000 + i);
        end
        wait_done();
        n_cmp++;
        if (s_overflow !== 1'b1 || s_done !== 1'b1 || s_count !== 3'd4) begin
            n_err++;
            $display("FAIL ovf_end: got ovf=%b done=%b count=%0d, expected 1 1 4", s_overflow, s_done, s_count);
        end
        set_fields(2'b11, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 32'h1111_2222);
        in_valid = 1'b1;
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (s_in_ready !== 1'b0 || s_im_we !== 1'b0 || s_count !== 3'd4) begin
            n_err++;
            $display("FAIL ovf_fifth: got rdy=%b we=%b count=%0d, expected 0 0 4", s_in_ready, s_im_we, s_count);
        end
        do_start();
        n_cmp++;
        if (s_overflow !== 1'b0 || s_done !== 1'b0 || s_count !== 3'd0 ||
            s_im_addr !== 32'h0000_3000 || s_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_rearm: got ovf=%b done=%b count=%0d addr=%h rdy=%b, expected 0 0 0 3000 1",
                     s_overflow, s_done, s_count, s_im_addr, s_in_ready);
        end
        check_q_empty("ovf");
        sel_small = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        im_ack = 1'b1;
        do_start();
        set_fields(2'b11, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 32'h1234_5678);
        send(1'b0, 32'h1234_5678);
        tick();
        im_ack = 1'b0;
        set_fields(2'b11, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 32'h8765_4321);
        send(1'b0, 32'h8765_4321);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        next_addr = 32'h0000_3000;
        n_cmp++;
        if (im_we !== 1'b0 || count !== 11'd0 || im_addr !== 32'h0000_3000 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL midrst: got we=%b count=%0d addr=%h busy=%b rdy=%b, expected 0 0 3000 0 0",
                     im_we, count, im_addr, busy, in_ready);
        end
        im_ack = 1'b1;
        do_start();
        set_fields(2'b10, 6'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h000_0040, 32'h0);
        send(1'b1, 32'h0C00_0040);
        wait_done();
        n_cmp++;
        if (count !== 11'd1 || done !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_fresh: got count=%0d done=%b, expected 1 1", count, done);
        end
        check_q_empty("midrst");
    endtask

    task automatic test_rearm();
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL rearm_pre: got done=%b, expected 1", done);
        end
        // start and in_valid together in DONE: only start is taken
        set_fields(2'b11, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 32'hCAFE_F00D);
        in_valid = 1'b1;
        do_start();
        in_valid = 1'b0;
        n_cmp++;
        if (done !== 1'b0 || count !== 11'd0 || im_addr !== 32'h0000_3000 || in_ready !== 1'b1 || im_we !== 1'b0) begin
            n_err++;
            $display("FAIL rearm: got done=%b count=%0d addr=%h rdy=%b we=%b, expected 0 0 3000 1 0",
                     done, count, im_addr, in_ready, im_we);
        end
        tick();
        n_cmp++;
        if (im_we !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rearm_idle: got we=%b rdy=%b, expected 0 1", im_we, in_ready);
        end
        check_q_empty("rearm");
    endtask

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog expired");
    end

    // Test sequence.
    initial begin
        test_reset();
        test_rtype();
        test_back_to_back();
        test_ack_stall();
        test_overflow();
        test_reset_mid_write();
        test_rearm();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
